// File: rtl/filt_read_arbiter.sv
// filt_read_arbiter
//   Round-robin arbiter that shares one memory read address stream among
//   NREQ filter accelerators. The owner's base offset and file size are
//   latched when it is granted. The block then issues one word address per
//   accepted beat. The owner receives a single-cycle done pulse after its
//   last beat has been accepted.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req             per-requester level request, held until own done
//   req_offset      packed base word addresses, slice i = [32i+31:32i]
//   req_filesize    packed lengths in 128-bit words, same slicing
//   mem_ready       memory accepts the current address this cycle
//   addr_valid      addr is valid
//   addr            current word address (offset + count, wraps mod 2^32)
//   grant           one-hot current owner
//   grant_id        binary index of current owner
//   done            one-cycle pulse to the owner after its last beat
//   busy            high whenever the FSM is not idle
//
// Build option
//   FILT_ARB_ABORT_EN  when defined, the owner dropping req during RUN
//                      abandons the transfer: there is no done pulse, and
//                      the round-robin pointer still moves past that owner.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no owner; pick next requester from rr_ptr upward, latch it
// LOAD   | clear beat counter; zero-length files skip straight to DONE
// RUN    | present offset+count; advance on each accepted beat
// DONE   | pulse done to owner, advance rr_ptr, release grant

module filt_read_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_offset,
    input  logic [NREQ*32-1:0]   req_filesize,
    input  logic                 mem_ready,
    output logic                 addr_valid,
    output logic [31:0]          addr,
    output logic [NREQ-1:0]      grant,
    output logic [IDW-1:0]       grant_id,
    output logic [NREQ-1:0]      done,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    grant_id_q;
    logic [NREQ-1:0]   grant_q;
    logic [31:0]       off_q;
    logic [31:0]       size_q;
    logic [31:0]       count;

    logic [IDW-1:0]    cand;
    logic [IDW-1:0]    pick_id;
    logic              pick_found;
    logic [31:0]       pick_off;
    logic [31:0]       pick_size;
    logic [IDW-1:0]    id_inc;
    logic              accept;
    logic              last_beat;
    logic              abort;

    // First requester at or above rr_ptr, wrapping modulo NREQ. This also
    // works when NREQ is not a power of two.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(rr_ptr) + i) % NREQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        pick_off  = '0;
        pick_size = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_id == IDW'(i)) begin
                pick_off  = req_offset[32*i +: 32];
                pick_size = req_filesize[32*i +: 32];
            end
        end
    end

    assign id_inc    = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
    assign accept    = (state == S_RUN) && mem_ready;
    assign last_beat = (count == size_q - 32'd1);

`ifdef FILT_ARB_ABORT_EN
    assign abort = (state == S_RUN) && !req[grant_id_q];
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (pick_found) state_nxt = S_LOAD;
            S_LOAD: state_nxt = (size_q == 32'd0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (accept && last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            grant_id_q <= '0;
            grant_q    <= '0;
            off_q      <= '0;
            size_q     <= '0;
            count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        off_q      <= pick_off;
                        size_q     <= pick_size;
                        grant_id_q <= pick_id;
                        grant_q    <= NREQ'(1) << pick_id;
                    end
                end
                S_LOAD: count <= '0;
                S_RUN: begin
                    if (abort) begin
                        rr_ptr     <= id_inc;
                        grant_q    <= '0;
                        grant_id_q <= '0;
                    end else if (accept && !last_beat) begin
                        count <= count + 32'd1;
                    end
                end
                S_DONE: begin
                    rr_ptr     <= id_inc;
                    grant_q    <= '0;
                    grant_id_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign addr_valid = (state == S_RUN);
    assign addr       = addr_valid ? (off_q + count) : '0;
    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    // The grant is still held during DONE, so it doubles as the one-hot done.
    assign done       = (state == S_DONE) ? grant_q : '0;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_filt_read_arbiter.sv
// Testbench for filt_read_arbiter. Observations are collected by a
// negedge monitor and compared against expectations built from the
// arbitration rules (round-robin order, offset..offset+size-1 per grant).

module tb_filt_read_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*32-1:0]  req_offset = '0;
    logic [NREQ*32-1:0]  req_filesize = '0;
    logic                mem_ready = 1'b0;
    logic                addr_valid;
    logic [31:0]         addr;
    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_id;
    logic [NREQ-1:0]     done;
    logic                busy;

    filt_read_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_offset   (req_offset),
        .req_filesize (req_filesize),
        .mem_ready    (mem_ready),
        .addr_valid   (addr_valid),
        .addr         (addr),
        .grant        (grant),
        .grant_id     (grant_id),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [31:0] acc_q[$];
    int          acc_cyc_q[$];
    logic [31:0] vaddr_q[$];
    int          done_q[$];
    int          done_cyc_q[$];
    int          first_valid = -1;
    bit          rdy_pat[$];
    bit          rdy_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (addr_valid) begin
                vaddr_q.push_back(addr);
                if (first_valid < 0) first_valid = cyc;
            end
            if (addr_valid && mem_ready) begin
                acc_q.push_back(addr);
                acc_cyc_q.push_back(cyc);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) begin
                    done_q.push_back(i);
                    done_cyc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        acc_q.delete();
        acc_cyc_q.delete();
        vaddr_q.delete();
        done_q.delete();
        done_cyc_q.delete();
        first_valid = -1;
        rdy_pat.delete();
    endtask

    task automatic set_src(input int i, input logic [31:0] off, input logic [31:0] fs);
        req_offset[32*i +: 32]   = off;
        req_filesize[32*i +: 32] = fs;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Drives mem_ready while addr_valid is high, counts done pulses and
    // optionally drops each requester's req when its done arrives.
    task automatic run_xfer(input int budget, input int n_done, input bit drop, output bit ok);
        int seen;
        seen = 0;
        for (int n = 0; n < budget && seen < n_done; n++) begin
            step();
            if (addr_valid) begin
                if (rdy_pat.size() > 0) mem_ready = rdy_pat.pop_front();
                else if (rdy_rand) mem_ready = 1'($urandom_range(0, 1));
                else mem_ready = 1'b1;
            end
            if (done != '0) begin
                seen++;
                if (drop) req = req & ~done;
            end
        end
        ok = (seen >= n_done);
        if (!drop) req = '0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        tests_run++; if (addr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", addr_valid); end
        tests_run++; if (addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", addr); end
        tests_run++; if (grant !== 4'b0) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0", grant); end
        tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        tests_run++; if (done !== 4'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int c0;
        bit ok;
        clear_obs();
        rdy_rand = 1'b0;
        set_src(0, 32'h100, 32'd4);
        c0 = cyc;
        req[0] = 1'b1;
        step();
        tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL single_grant: got %b expected 0001", grant); end
        tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL single_grant_id: got %0d expected 0", grant_id); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b expected 1", busy); end
        run_xfer(40, 1, 1'b1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_timeout: got no done expected done"); end
        tests_run++; if (acc_q.size() != 4) begin tests_failed++; $display("FAIL single_beats: got %0d expected 4", acc_q.size()); end
        for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
            tests_run++;
            if (acc_q[k] !== 32'h100 + 32'(k)) begin tests_failed++; $display("FAIL single_addr%0d: got %h expected %h", k, acc_q[k], 32'h100 + 32'(k)); end
        end
        if (acc_cyc_q.size() == 4) begin
            tests_run++; if (acc_cyc_q[3] - acc_cyc_q[0] != 3) begin tests_failed++; $display("FAIL single_consecutive: got span %0d expected 3", acc_cyc_q[3] - acc_cyc_q[0]); end
        end
        tests_run++; if (first_valid - c0 != 2) begin tests_failed++; $display("FAIL single_latency: got %0d expected 2", first_valid - c0); end
        tests_run++; if (done_q.size() != 1 || done_q[0] != 0) begin tests_failed++; $display("FAIL single_done: got %0d pulses expected 1 on req0", done_q.size()); end
        if (done_cyc_q.size() == 1 && acc_cyc_q.size() == 4) begin
            tests_run++; if (done_cyc_q[0] - acc_cyc_q[3] != 1) begin tests_failed++; $display("FAIL single_done_time: got %0d expected 1", done_cyc_q[0] - acc_cyc_q[3]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] exp_v[5];
        exp_v = '{32'h20, 32'h21, 32'h21, 32'h21, 32'h22};
        clear_obs();
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        set_src(1, 32'h20, 32'd3);
        req[1] = 1'b1;
        run_xfer(40, 1, 1'b1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_timeout: got no done expected done"); end
        tests_run++; if (vaddr_q.size() != 5) begin tests_failed++; $display("FAIL bp_valid_cycles: got %0d expected 5", vaddr_q.size()); end
        for (int k = 0; k < 5 && k < vaddr_q.size(); k++) begin
            tests_run++;
            if (vaddr_q[k] !== exp_v[k]) begin tests_failed++; $display("FAIL bp_addr%0d: got %h expected %h", k, vaddr_q[k], exp_v[k]); end
        end
        tests_run++; if (acc_q.size() != 3) begin tests_failed++; $display("FAIL bp_accepts: got %0d expected 3", acc_q.size()); end
        tests_run++; if (done_q.size() != 1 || done_q[0] != 1) begin tests_failed++; $display("FAIL bp_done: got %0d pulses expected 1 on req1", done_q.size()); end
    endtask

    task automatic test_zero_size();
        bit ok;
        int c0;
        clear_obs();
        set_src(2, 32'h77, 32'd0);
        c0 = cyc;
        req[2] = 1'b1;
        run_xfer(20, 1, 1'b1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL zero_timeout: got no done expected done"); end
        tests_run++; if (vaddr_q.size() != 0) begin tests_failed++; $display("FAIL zero_valid: got %0d valid cycles expected 0", vaddr_q.size()); end
        tests_run++; if (done_q.size() != 1 || done_q[0] != 2) begin tests_failed++; $display("FAIL zero_done: got %0d pulses expected 1 on req2", done_q.size()); end
        if (done_cyc_q.size() == 1) begin
            tests_run++; if (done_cyc_q[0] - c0 != 2) begin tests_failed++; $display("FAIL zero_done_time: got %0d expected 2", done_cyc_q[0] - c0); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] exp_a[3];
        exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        clear_obs();
        rdy_rand = 1'b1;
        set_src(1, 32'hFFFF_FFFE, 32'd3);
        req[1] = 1'b1;
        run_xfer(60, 1, 1'b1, ok);
        rdy_rand = 1'b0;
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL wrap_timeout: got no done expected done"); end
        tests_run++; if (acc_q.size() != 3) begin tests_failed++; $display("FAIL wrap_beats: got %0d expected 3", acc_q.size()); end
        for (int k = 0; k < 3 && k < acc_q.size(); k++) begin
            tests_run++;
            if (acc_q[k] !== exp_a[k]) begin tests_failed++; $display("FAIL wrap_addr%0d: got %h expected %h", k, acc_q[k], exp_a[k]); end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_ids[6];
        exp_ids = '{0, 1, 3, 0, 1, 3};
        do_reset();
        clear_obs();
        for (int i = 0; i < NREQ; i++) set_src(i, 32'(i * 16), 32'd1);
        req = 4'b1011;
        run_xfer(100, 6, 1'b0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rr_timeout: got fewer than 6 dones"); end
        tests_run++; if (done_q.size() != 6) begin tests_failed++; $display("FAIL rr_count: got %0d expected 6", done_q.size()); end
        for (int k = 0; k < 6 && k < done_q.size(); k++) begin
            tests_run++;
            if (done_q[k] != exp_ids[k]) begin tests_failed++; $display("FAIL rr_order%0d: got %0d expected %0d", k, done_q[k], exp_ids[k]); end
        end
        for (int k = 0; k < 6 && k < acc_q.size(); k++) begin
            tests_run++;
            if (acc_q[k] !== 32'(exp_ids[k] * 16)) begin tests_failed++; $display("FAIL rr_addr%0d: got %h expected %h", k, acc_q[k], 32'(exp_ids[k] * 16)); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        clear_obs();
        set_src(3, 32'h400, 32'd8);
        req[3] = 1'b1;
        n = 0;
        while (acc_q.size() < 2 && n < 50) begin
            step();
            mem_ready = 1'b1;
            n++;
        end
        tests_run++; if (acc_q.size() < 2) begin tests_failed++; $display("FAIL rmid_start: got %0d beats expected 2", acc_q.size()); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (addr_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid: got %b expected 0", addr_valid); end
        tests_run++; if (addr !== 32'h0) begin tests_failed++; $display("FAIL rmid_addr: got %h expected 0", addr); end
        tests_run++; if (grant !== 4'b0 || grant_id !== 2'd0) begin tests_failed++; $display("FAIL rmid_grant: got %b/%0d expected 0/0", grant, grant_id); end
        tests_run++; if (busy !== 1'b0 || done !== 4'b0) begin tests_failed++; $display("FAIL rmid_busy_done: got %b/%b expected 0/0", busy, done); end
        step();
        rst = 1'b0;
        tests_run++; if (done_q.size() != 0) begin tests_failed++; $display("FAIL rmid_no_done: got %0d pulses expected 0", done_q.size()); end
        clear_obs();
        run_xfer(60, 1, 1'b1, ok);
        tests_run++; if (!ok || acc_q.size() != 8) begin tests_failed++; $display("FAIL rmid_restart_beats: got %0d expected 8", acc_q.size()); end
        tests_run++; if (acc_q.size() == 0 || acc_q[0] !== 32'h400) begin tests_failed++; $display("FAIL rmid_restart_first: got %h expected 400", acc_q.size() ? acc_q[0] : 32'hx); end
    endtask

    task automatic test_abort();
        bit ok;
        bit dropped;
        int drop_cyc;
        logic v_after;
        clear_obs();
        dropped = 1'b0;
        drop_cyc = 0;
        v_after = 1'bx;
        set_src(0, 32'h500, 32'd5);
        req[0] = 1'b1;
        for (int n = 0; n < 25; n++) begin
            step();
            if (dropped && cyc == drop_cyc + 1) v_after = addr_valid;
            if (!dropped && acc_q.size() == 2) begin
                req[0] = 1'b0;
                mem_ready = 1'b0;
                dropped = 1'b1;
                drop_cyc = cyc;
            end else begin
                mem_ready = 1'b1;
            end
        end
        tests_run++; if (!dropped) begin tests_failed++; $display("FAIL abort_setup: got no 2nd beat expected drop point"); end
`ifdef FILT_ARB_ABORT_EN
        tests_run++; if (v_after !== 1'b0) begin tests_failed++; $display("FAIL abort_valid: got %b expected 0", v_after); end
        tests_run++; if (acc_q.size() != 2) begin tests_failed++; $display("FAIL abort_beats: got %0d expected 2", acc_q.size()); end
        tests_run++; if (done_q.size() != 0) begin tests_failed++; $display("FAIL abort_done: got %0d pulses expected 0", done_q.size()); end
`else
        tests_run++; if (v_after !== 1'b1) begin tests_failed++; $display("FAIL noabort_valid: got %b expected 1", v_after); end
        tests_run++; if (acc_q.size() != 5) begin tests_failed++; $display("FAIL noabort_beats: got %0d expected 5", acc_q.size()); end
        tests_run++; if (acc_q.size() == 5 && acc_q[4] !== 32'h504) begin tests_failed++; $display("FAIL noabort_last: got %h expected 504", acc_q[4]); end
        tests_run++; if (done_q.size() != 1 || done_q[0] != 0) begin tests_failed++; $display("FAIL noabort_done: got %0d pulses expected 1 on req0", done_q.size()); end
`endif
        // Either way rr_ptr must now point past requester 0.
        clear_obs();
        set_src(0, 32'h600, 32'd1);
        set_src(1, 32'h700, 32'd1);
        req = 4'b0011;
        run_xfer(40, 2, 1'b1, ok);
        tests_run++; if (!ok || done_q.size() != 2) begin tests_failed++; $display("FAIL abort_rr_count: got %0d expected 2", done_q.size()); end
        tests_run++; if (done_q.size() == 0 || done_q[0] != 1) begin tests_failed++; $display("FAIL abort_rr_first: got %0d expected 1", done_q.size() ? done_q[0] : -1); end
    endtask

    task automatic test_random();
        int model_rr;
        do_reset();
        model_rr = 0;
        rdy_rand = 1'b1;
        for (int it = 0; it < 12; it++) begin
            logic [NREQ-1:0] mask;
            logic [NREQ-1:0] pend;
            logic [31:0] offs[NREQ];
            int sizes[NREQ];
            int exp_ids[$];
            logic [31:0] exp_addr[$];
            int p;
            bit ok;
            clear_obs();
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                offs[i]  = $urandom;
                if ($urandom_range(0, 3) == 0) offs[i] = 32'hFFFF_FFFC;
                sizes[i] = $urandom_range(0, 6);
                set_src(i, offs[i], 32'(sizes[i]));
            end
            pend = mask;
            p = model_rr;
            while (pend != '0) begin
                for (int s = 0; s < NREQ; s++) begin
                    int j;
                    j = (p + s) % NREQ;
                    if (pend[j]) begin
                        exp_ids.push_back(j);
                        for (int k = 0; k < sizes[j]; k++) exp_addr.push_back(offs[j] + 32'(k));
                        pend[j] = 1'b0;
                        p = (j + 1) % NREQ;
                        break;
                    end
                end
            end
            model_rr = p;
            req = mask;
            run_xfer(400, exp_ids.size(), 1'b1, ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand%0d_timeout: got fewer dones than %0d", it, exp_ids.size()); end
            tests_run++; if (done_q.size() != exp_ids.size()) begin tests_failed++; $display("FAIL rand%0d_done_count: got %0d expected %0d", it, done_q.size(), exp_ids.size()); end
            for (int k = 0; k < exp_ids.size() && k < done_q.size(); k++) begin
                tests_run++;
                if (done_q[k] != exp_ids[k]) begin tests_failed++; $display("FAIL rand%0d_order%0d: got %0d expected %0d", it, k, done_q[k], exp_ids[k]); end
            end
            tests_run++; if (acc_q.size() != exp_addr.size()) begin tests_failed++; $display("FAIL rand%0d_beats: got %0d expected %0d", it, acc_q.size(), exp_addr.size()); end
            for (int k = 0; k < exp_addr.size() && k < acc_q.size(); k++) begin
                tests_run++;
                if (acc_q[k] !== exp_addr[k]) begin tests_failed++; $display("FAIL rand%0d_addr%0d: got %h expected %h", it, k, acc_q[k], exp_addr[k]); end
            end
        end
        rdy_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_zero_size();
        test_wrap();
        test_round_robin();
        test_reset_mid();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
